// File: rtl/pixel_scan_driver.sv
// Raster-order sequencer feeding pixel_shader and the framebuffer write port.
// One pixel in flight: ARM flushes the shader, RUN waits for done, WRITE stores the result.
module pixel_scan_driver #(
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120,
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_go,
  input  logic              shader_done,
  input  logic [23:0]       shader_rgb,
  output logic              shader_start,
  output logic [31:0]       pix_x,
  output logic [31:0]       pix_y,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_data,
  output logic              fb_we,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FEND  = 3'd4;

  localparam logic [23:0] ERR_RGB = 24'hFF00FF;

  logic [2:0]    state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] cnt;
  logic          x_last;
  logic          y_last;

  assign x_last = (x == XW'(WIDTH - 1));
  assign y_last = (y == YW'(HEIGHT - 1));

  // All outputs decode straight from flops; no input reaches them combinationally.
  assign shader_start = (state == S_RUN) || (state == S_WRITE);
  assign busy         = (state != S_IDLE);
  assign fb_we        = (state == S_WRITE);
  assign frame_done   = (state == S_FEND);
  assign pix_x        = 32'(x);
  assign pix_y        = 32'(y);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      x           <= '0;
      y           <= '0;
      cnt         <= '0;
      fb_addr     <= '0;
      fb_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (frame_go) begin
            state       <= S_ARM;
            x           <= '0;
            y           <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_ARM: begin
          cnt     <= '0;
          fb_addr <= ADDR_W'(32'(y) * WIDTH + 32'(x));
          state   <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          // done has priority over a timeout landing in the same cycle
          if (shader_done) begin
            fb_data <= shader_rgb;
            state   <= S_WRITE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            fb_data     <= ERR_RGB;
            timeout_err <= 1'b1;
            state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (x_last && y_last) begin
            state <= S_FEND;
          end else begin
            state <= S_ARM;
            if (x_last) begin
              x <= '0;
              y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        S_FEND: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_scan_driver.sv
// Directed bench for pixel_scan_driver with a scoreboard of expected framebuffer writes.
// Uses a 160x4 frame so rows wrap at 159/160 while keeping the run short.
module tb_pixel_scan_driver;

  localparam int W   = 160;
  localparam int H   = 4;
  localparam int AW  = 15;
  localparam int TO  = 256;
  localparam int NPX = W * H;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_go;
  logic          shader_done;
  logic [23:0]   shader_rgb;
  logic          shader_start;
  logic [31:0]   pix_x;
  logic [31:0]   pix_y;
  logic [AW-1:0] fb_addr;
  logic [23:0]   fb_data;
  logic          fb_we;
  logic          busy;
  logic          frame_done;
  logic          timeout_err;

  pixel_scan_driver #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_go(frame_go),
    .shader_done(shader_done),
    .shader_rgb(shader_rgb),
    .shader_start(shader_start),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .fb_we(fb_we),
    .busy(busy),
    .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Shader model: done after dly cycles of start high; can hang or answer late.
  bit hang_en = 1'b0;
  bit slow_en = 1'b0;
  int scnt    = 0;

  always @(negedge clk) begin
    int dly;
    dly = (slow_en && pix_x == 7 && pix_y == 1) ? TO : 4;
    shader_rgb <= {pix_x[7:0], pix_y[7:0], 8'hA5};
    if (!shader_start) begin
      scnt        <= 0;
      shader_done <= 1'b0;
    end else begin
      scnt        <= scnt + 1;
      shader_done <= !(hang_en && pix_x == 5 && pix_y == 2) && (scnt + 1 == dly);
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          x;
    int          y;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   last_wr   = 0;
  int   nwr       = 0;
  int   nfd       = 0;
  bit   wrap_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_frame(input bit hang, input bit slow);
    exp_t e;
    for (int i = 0; i < NPX; i++) begin
      e.x    = i % W;
      e.y    = i / W;
      e.addr = 32'(i);
      e.data = {8'h0, 8'(e.x), 8'(e.y), 8'hA5};
      e.gap  = (i == 0) ? 0 : 6;
      if (hang && e.x == 5 && e.y == 2) begin
        e.data = 32'h00FF00FF;
        e.gap  = TO + 2;
      end
      if (slow && e.x == 7 && e.y == 1) e.gap = TO + 2;
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (wrap_pend) begin
      wrap_pend = 1'b0;
      chk("wrap_arm", {31'b0, shader_start}, 32'd0);
      chk("wrap_x", pix_x, 32'd0);
      chk("wrap_y", pix_y, 32'd1);
    end
    if (fb_we) begin
      if (sb.size() == 0) begin
        chk("sb_empty_on_write", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(fb_addr), e.addr);
        chk("wr_data", {8'h0, fb_data}, e.data);
        chk("wr_x", pix_x, 32'(e.x));
        chk("wr_y", pix_y, 32'(e.y));
        if (e.gap != 0) chk("wr_gap", 32'(cyc - last_wr), 32'(e.gap));
        if (e.data == 32'h00FF00FF) chk("to_err_set", {31'b0, timeout_err}, 32'd1);
        if (e.addr == 32'(W - 1)) wrap_pend = 1'b1;
      end
      last_wr = cyc;
      nwr++;
    end
    if (frame_done) begin
      nfd++;
      chk("fd_after_last", 32'(cyc - last_wr), 32'd1);
      chk("fd_sb_empty", 32'(sb.size()), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, {31'b0, shader_start}, 32'd0);
    chk({tag, "_x"}, pix_x, 32'd0);
    chk({tag, "_y"}, pix_y, 32'd0);
    chk({tag, "_addr"}, 32'(fb_addr), 32'd0);
    chk({tag, "_data"}, {8'h0, fb_data}, 32'd0);
    chk({tag, "_we"}, {31'b0, fb_we}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_fd"}, {31'b0, frame_done}, 32'd0);
    chk({tag, "_err"}, {31'b0, timeout_err}, 32'd0);
  endtask

  task automatic start_frame(input bit hang, input bit slow);
    push_frame(hang, slow);
    hang_en  = hang;
    slow_en  = slow;
    frame_go = 1'b1;
    tick();
    frame_go = 1'b0;
    chk("go_busy", {31'b0, busy}, 32'd1);
    chk("go_arm", {31'b0, shader_start}, 32'd0);
    chk("go_x", pix_x, 32'd0);
    chk("go_y", pix_y, 32'd0);
    chk("go_err_clr", {31'b0, timeout_err}, 32'd0);
  endtask

  task automatic wait_frame(input int go_at);
    int fd0;
    int base;
    int guard;
    bit pulsed;
    fd0    = nfd;
    base   = nwr;
    guard  = 0;
    pulsed = 1'b0;
    while (nfd == fd0 && guard < 20000) begin
      if (!pulsed && go_at >= 0 && nwr - base == go_at) begin
        frame_go = 1'b1;
        pulsed   = 1'b1;
      end else begin
        frame_go = 1'b0;
      end
      tick();
      guard++;
    end
    frame_go = 1'b0;
    chk("frame_in_budget", {31'b0, guard < 20000}, 32'd1);
    chk("frame_writes", 32'(nwr - base), 32'(NPX));
  endtask

  initial begin
    int guard;
    int base;
    reset    = 1'b1;
    frame_go = 1'b1;
    repeat (3) tick();
    chk_all_zero("rst");
    reset    = 1'b0;
    frame_go = 1'b0;
    repeat (2) tick();
    chk("post_rst_idle", {31'b0, busy}, 32'd0);

    // Frame 1: pixel (5,2) never answers and is forced to the error colour.
    start_frame(1'b1, 1'b0);
    wait_frame(-1);
    chk("f1_done_cnt", 32'(nfd), 32'd1);
    repeat (3) tick();
    chk("f1_idle", {31'b0, busy}, 32'd0);
    chk("f1_err_sticky", {31'b0, timeout_err}, 32'd1);

    // Frame 2: done coincides with timeout on (7,1); stray frame_go mid-frame.
    start_frame(1'b0, 1'b1);
    wait_frame(100);
    chk("f2_done_cnt", 32'(nfd), 32'd2);
    chk("f2_no_err", {31'b0, timeout_err}, 32'd0);
    repeat (10) tick();
    chk("f2_not_queued", {31'b0, busy}, 32'd0);
    chk("f2_sb_left", 32'(sb.size()), 32'd0);

    // Frame 3: aborted by reset while in RUN of pixel 500.
    start_frame(1'b0, 1'b0);
    base  = nwr - 0;
    guard = 0;
    while (nwr - base < 500 && guard < 10000) begin
      tick();
      guard++;
    end
    chk("f3_reach_500", {31'b0, guard < 10000}, 32'd1);
    tick();
    tick();
    chk("f3_in_run", {30'b0, shader_start, fb_we}, 32'd2);
    reset = 1'b1;
    tick();
    chk_all_zero("midrst");
    reset = 1'b0;
    sb.delete();
    tick();

    // Frame 4: clean restart from address 0.
    start_frame(1'b0, 1'b0);
    wait_frame(-1);
    chk("f4_done_cnt", 32'(nfd), 32'd3);
    chk("f4_sb_left", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
